// File: rtl/mips_fetch_pkg.sv
// Shared fetch-stage definitions: halt sentinel, reset PC, FSM states and
// the IF/ID pipeline record consumed by the decode stage.
package mips_fetch_pkg;

    localparam logic [15:0] HALT_WORD        = 16'hFFFF;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc_plus1;
        logic        valid;
    } if_id_t;

endpackage

// File: rtl/fetch_pc_reg.sv
// 16-bit program counter: async reset, load (highest priority), increment
// with natural wrap at 16'hFFFF, otherwise hold.
module fetch_pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        inc,
    output logic [15:0] pc
);

    // PC update: load beats increment, neither means hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + 16'd1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction memory address, captures
// returned words into the IF/ID register, and stops on the halt sentinel.
// Redirects flush IF/ID and also leave HALT, since a halt word seen behind a
// taken branch is speculative.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC  = mips_fetch_pkg::RESET_PC_DEFAULT,
    parameter logic [15:0] HALT_WORD = mips_fetch_pkg::HALT_WORD
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    output logic [15:0] if_id_instr,
    output logic [15:0] if_id_pc,
    output logic [15:0] if_id_pc_plus1,
    output logic        if_id_valid,
    output logic        halted,
    output logic [15:0] fetch_count
);

    import mips_fetch_pkg::*;

    logic [15:0]  pc;
    fetch_state_t state;
    if_id_t       if_id;
    logic [15:0]  count;
    logic         is_halt_word;
    logic         fetch_ok;

    // A real fetch happens only in RUN, unstalled, unredirected, non-halt word
    always_comb begin
        is_halt_word = (imem_data == HALT_WORD);
        fetch_ok     = (state == RUN) && !stall && !redirect_valid && !is_halt_word;
    end

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (redirect_valid),
        .load_value (redirect_target),
        .inc        (fetch_ok),
        .pc         (pc)
    );

    // FSM, IF/ID register and saturating delivered-instruction counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            if_id <= '0;
            count <= '0;
        end else if (redirect_valid) begin
            state       <= RUN;
            if_id.valid <= 1'b0;
        end else if (state == RUN && !stall) begin
            if (is_halt_word) begin
                state       <= HALT;
                if_id.valid <= 1'b0;
            end else begin
                if_id.instr    <= imem_data;
                if_id.pc       <= pc;
                if_id.pc_plus1 <= pc + 16'd1;
                if_id.valid    <= 1'b1;
                if (count != 16'hFFFF) begin
                    count <= count + 16'd1;
                end
            end
        end
    end

    // Output mapping; memory address follows the PC in every state
    always_comb begin
        imem_addr      = pc;
        if_id_instr    = if_id.instr;
        if_id_pc       = if_id.pc;
        if_id_pc_plus1 = if_id.pc_plus1;
        if_id_valid    = if_id.valid;
        halted         = (state == HALT);
        fetch_count    = count;
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a per-cycle vector table for the
// main program run, stall, redirect and halt cases, plus hand sequences for
// asynchronous reset and fetch counter saturation.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_target;
    logic [15:0] if_id_instr;
    logic [15:0] if_id_pc;
    logic [15:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [15:0] mem [0:1023];

    int n_cmp;
    int n_bad;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [15:0] tgt;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
        logic [15:0] e_pp1;
        logic        e_valid;
        logic        e_halt;
        logic [15:0] e_addr;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t rows [23];

    instruction_fetch_unit #(
        .RESET_PC  (16'h0000),
        .HALT_WORD (16'hFFFF)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus1  (if_id_pc_plus1),
        .if_id_valid     (if_id_valid),
        .halted          (halted),
        .fetch_count     (fetch_count)
    );

    assign imem_data = mem[imem_addr[9:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [15:0] instr, input logic [15:0] pc,
                           input logic [15:0] pp1, input logic valid, input logic halt,
                           input logic [15:0] addr, input logic [15:0] cnt);
        chk({tag, ".instr"}, if_id_instr, instr);
        chk({tag, ".pc"},    if_id_pc, pc);
        chk({tag, ".pp1"},   if_id_pc_plus1, pp1);
        chk({tag, ".valid"}, {15'd0, if_id_valid}, {15'd0, valid});
        chk({tag, ".halt"},  {15'd0, halted}, {15'd0, halt});
        chk({tag, ".addr"},  imem_addr, addr);
        chk({tag, ".cnt"},   fetch_count, cnt);
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic [15:0] t,
                                input logic [15:0] ei, input logic [15:0] ep, input logic [15:0] epp,
                                input logic ev, input logic eh, input logic [15:0] ea,
                                input logic [15:0] ec);
        vec_t v;
        v.stall = s; v.redir = r; v.tgt = t;
        v.e_instr = ei; v.e_pc = ep; v.e_pp1 = epp; v.e_valid = ev; v.e_halt = eh;
        v.e_addr = ea; v.e_cnt = ec;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int unsigned i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[0] = 16'h2009; mem[1] = 16'h200A; mem[2] = 16'h012A; mem[3] = 16'h012B;
        mem[4] = 16'h014B; mem[5] = 16'h014B; mem[6] = 16'h016A; mem[7] = 16'h018B;
        mem[8] = 16'hFFFF; mem[1023] = 16'h1234;

        //            st  rd  tgt       instr     pc        pp1       v  h  addr      cnt
        rows[0]  = mk(0, 0, 16'h0000, 16'h2009, 16'h0000, 16'h0001, 1, 0, 16'h0001, 16'd1);
        rows[1]  = mk(0, 0, 16'h0000, 16'h200A, 16'h0001, 16'h0002, 1, 0, 16'h0002, 16'd2);
        rows[2]  = mk(0, 0, 16'h0000, 16'h012A, 16'h0002, 16'h0003, 1, 0, 16'h0003, 16'd3);
        rows[3]  = mk(1, 0, 16'h0000, 16'h012A, 16'h0002, 16'h0003, 1, 0, 16'h0003, 16'd3);
        rows[4]  = mk(1, 0, 16'h0000, 16'h012A, 16'h0002, 16'h0003, 1, 0, 16'h0003, 16'd3);
        rows[5]  = mk(1, 0, 16'h0000, 16'h012A, 16'h0002, 16'h0003, 1, 0, 16'h0003, 16'd3);
        rows[6]  = mk(0, 0, 16'h0000, 16'h012B, 16'h0003, 16'h0004, 1, 0, 16'h0004, 16'd4);
        rows[7]  = mk(0, 0, 16'h0000, 16'h014B, 16'h0004, 16'h0005, 1, 0, 16'h0005, 16'd5);
        rows[8]  = mk(0, 0, 16'h0000, 16'h014B, 16'h0005, 16'h0006, 1, 0, 16'h0006, 16'd6);
        rows[9]  = mk(0, 0, 16'h0000, 16'h016A, 16'h0006, 16'h0007, 1, 0, 16'h0007, 16'd7);
        rows[10] = mk(0, 0, 16'h0000, 16'h018B, 16'h0007, 16'h0008, 1, 0, 16'h0008, 16'd8);
        rows[11] = mk(0, 0, 16'h0000, 16'h018B, 16'h0007, 16'h0008, 0, 1, 16'h0008, 16'd8);
        rows[12] = mk(1, 0, 16'h0000, 16'h018B, 16'h0007, 16'h0008, 0, 1, 16'h0008, 16'd8);
        rows[13] = mk(0, 0, 16'h0000, 16'h018B, 16'h0007, 16'h0008, 0, 1, 16'h0008, 16'd8);
        rows[14] = mk(0, 1, 16'h0001, 16'h018B, 16'h0007, 16'h0008, 0, 0, 16'h0001, 16'd8);
        rows[15] = mk(0, 0, 16'h0000, 16'h200A, 16'h0001, 16'h0002, 1, 0, 16'h0002, 16'd9);
        rows[16] = mk(1, 1, 16'h0006, 16'h200A, 16'h0001, 16'h0002, 0, 0, 16'h0006, 16'd9);
        rows[17] = mk(0, 0, 16'h0000, 16'h016A, 16'h0006, 16'h0007, 1, 0, 16'h0007, 16'd10);
        rows[18] = mk(0, 1, 16'hFFFF, 16'h016A, 16'h0006, 16'h0007, 0, 0, 16'hFFFF, 16'd10);
        rows[19] = mk(0, 0, 16'h0000, 16'h1234, 16'hFFFF, 16'h0000, 1, 0, 16'h0000, 16'd11);
        rows[20] = mk(0, 0, 16'h0000, 16'h2009, 16'h0000, 16'h0001, 1, 0, 16'h0001, 16'd12);
        rows[21] = mk(0, 1, 16'h0008, 16'h2009, 16'h0000, 16'h0001, 0, 0, 16'h0008, 16'd12);
        rows[22] = mk(0, 0, 16'h0000, 16'h2009, 16'h0000, 16'h0001, 0, 1, 16'h0008, 16'd12);

        rst_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 16'h0000;
        #1;
        chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            stall = rows[i].stall;
            redirect_valid = rows[i].redir;
            redirect_target = rows[i].tgt;
            @(posedge clk);
            #1;
            chk_all($sformatf("row%0d", i), rows[i].e_instr, rows[i].e_pc, rows[i].e_pp1,
                    rows[i].e_valid, rows[i].e_halt, rows[i].e_addr, rows[i].e_cnt);
        end
        stall = 1'b0;
        redirect_valid = 1'b0;

        // Asynchronous reset while halted: clears immediately, no edge needed
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("rst_halt", 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Run to pc=5, then reset between edges
        repeat (5) @(posedge clk);
        #1;
        chk_all("run5", 16'h014B, 16'h0004, 16'h0005, 1, 0, 16'h0005, 16'd5);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all("rst_run", 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_all("refetch", 16'h2009, 16'h0000, 16'h0001, 1, 0, 16'h0001, 16'd1);

        // Counter saturation: remove the halt word so fetch never stops
        mem[8] = 16'h0000;
        do_reset();
        repeat (65534) @(posedge clk);
        #1;
        chk("cnt_fffe", fetch_count, 16'hFFFE);
        @(posedge clk);
        #1;
        chk("cnt_ffff", fetch_count, 16'hFFFF);
        @(posedge clk);
        #1;
        chk("cnt_sat", fetch_count, 16'hFFFF);
        chk("sat_valid", {15'd0, if_id_valid}, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
